lstm_seq_ctrl: RTL

- Timestep sequencer for one LSTM layer of NUM_LSTM combinational cells sharing input vector x(t).
- Accepts one x(t) frame per timestep over a valid/ready handshake.
- Builds the concatenated cell input {h(t-1), x(t)}, holds c(t-1)/h(t-1) state registers, waits a fixed settle time, then captures h(t)/c(t).
- Also serialises weight-memory write strobes (wr/rd_addr/wr_addr) to the cells so an update never overlaps a forward pass.

---
 rtl/lstm_pkg.sv | 22 ++
 rtl/lstm_seq_ctrl_if.sv | 26 ++
 rtl/lstm_state_reg.sv | 29 ++
 rtl/lstm_seq_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/lstm_pkg.sv
// Shared types and constants for the LSTM timestep sequencer.
package lstm_pkg;

  localparam int ADDR_W    = 9;
  localparam int WIDTH_DEF = 32;
  localparam int FRAC_DEF  = 24;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_X  = 3'd1,
    SETTLE  = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4,
    UPDATE  = 3'd5
  } seq_state_t;

  // A zero-length sequence still runs one timestep.
  function automatic logic [ADDR_W-1:0] last_step(input logic [ADDR_W-1:0] seq_len);
    return (seq_len == '0) ? '0 : seq_len - 1'b1;
  endfunction

endpackage

// File: rtl/lstm_seq_ctrl_if.sv
// Frame and weight-update handshakes between a producer (master) and the sequencer (slave).
interface lstm_seq_ctrl_if
  import lstm_pkg::*;
#(
  parameter int NUM   = 68,
  parameter int WIDTH = WIDTH_DEF
);

  logic                 i_x_valid;
  logic                 o_x_ready;
  logic [NUM*WIDTH-1:0] i_x;
  logic                 i_upd_req;
  logic [ADDR_W-1:0]    i_upd_addr;
  logic                 o_upd_ack;

  modport master (
    output i_x_valid, i_x, i_upd_req, i_upd_addr,
    input  o_x_ready, o_upd_ack
  );

  modport slave (
    input  i_x_valid, i_x, i_upd_req, i_upd_addr,
    output o_x_ready, o_upd_ack
  );

endinterface

// File: rtl/lstm_state_reg.sv
// h(t-1)/c(t-1) state registers for all cells; capture wins over clear.
module lstm_state_reg #(
  parameter int WIDTH    = 32,
  parameter int NUM_LSTM = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clr,
  input  logic                             cap,
  input  logic        [NUM_LSTM*WIDTH-1:0] h_in,
  input  logic        [NUM_LSTM*WIDTH-1:0] c_in,
  output logic signed [NUM_LSTM*WIDTH-1:0] h,
  output logic signed [NUM_LSTM*WIDTH-1:0] c
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h <= '0;
      c <= '0;
    end else if (cap) begin
      h <= h_in;
      c <= c_in;
    end else if (clr) begin
      h <= '0;
      c <= '0;
    end
  end

endmodule

// File: rtl/lstm_seq_ctrl.sv
// Timestep sequencer for one LSTM layer; serialises weight updates against forward passes.
// Define LSTM_STATE_KEEP_EN to carry h/c across sequences (cleared only by reset).
module lstm_seq_ctrl
  import lstm_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int NUM        = 68,
  parameter int NUM_LSTM   = 8,
  parameter int SETTLE_CYC = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_start,
  input  logic [ADDR_W-1:0]               i_seq_len,
  output logic                            o_busy,
  output logic                            o_done,
  lstm_seq_ctrl_if.slave                  xif,
  output logic [(NUM+NUM_LSTM)*WIDTH-1:0] o_cell_x,
  output logic [NUM_LSTM*WIDTH-1:0]       o_prev_state,
  input  logic [NUM_LSTM*WIDTH-1:0]       i_cell_h,
  input  logic [NUM_LSTM*WIDTH-1:0]       i_cell_c,
  output logic [NUM_LSTM*WIDTH-1:0]       o_h,
  output logic                            o_h_valid,
  output logic [ADDR_W-1:0]               o_t,
  output logic                            o_wr,
  output logic [ADDR_W-1:0]               o_rd_addr,
  output logic [ADDR_W-1:0]               o_wr_addr
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  seq_state_t                        state;
  logic        [CNT_W-1:0]           settle;
  logic        [ADDR_W-1:0]          len_m1;
  logic                              x_ready;
  logic                              upd_ack;
  logic signed [NUM*WIDTH-1:0]       x_reg;
  logic signed [NUM_LSTM*WIDTH-1:0]  h_q;
  logic signed [NUM_LSTM*WIDTH-1:0]  c_q;
  logic                              state_clr;
  logic                              state_cap;

  assign xif.o_x_ready = x_ready;
  assign xif.o_upd_ack = upd_ack;
  assign o_cell_x      = {h_q, x_reg};
  assign o_prev_state  = c_q;
  assign state_cap     = (state == CAPTURE);

`ifdef LSTM_STATE_KEEP_EN
  assign state_clr = 1'b0;
`else
  assign state_clr = (state == IDLE) && i_start && !xif.i_upd_req;
`endif

  lstm_state_reg #(
    .WIDTH    (WIDTH),
    .NUM_LSTM (NUM_LSTM)
  ) u_state (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_clr),
    .cap  (state_cap),
    .h_in (i_cell_h),
    .c_in (i_cell_c),
    .h    (h_q),
    .c    (c_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      settle    <= '0;
      len_m1    <= '0;
      x_ready   <= 1'b0;
      upd_ack   <= 1'b0;
      x_reg     <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_h       <= '0;
      o_h_valid <= 1'b0;
      o_t       <= '0;
      o_wr      <= 1'b0;
      o_rd_addr <= '0;
      o_wr_addr <= '0;
    end else begin
      o_done    <= 1'b0;
      o_h_valid <= 1'b0;
      o_wr      <= 1'b0;
      upd_ack   <= 1'b0;
      o_wr_addr <= '0;
      unique case (state)
        // Pending weight writes go first so they never overlap a forward pass.
        IDLE: begin
          if (xif.i_upd_req) begin
            state     <= UPDATE;
            o_busy    <= 1'b1;
            o_wr      <= 1'b1;
            o_wr_addr <= xif.i_upd_addr;
            upd_ack   <= 1'b1;
          end else if (i_start) begin
            state     <= WAIT_X;
            o_busy    <= 1'b1;
            x_ready   <= 1'b1;
            o_t       <= '0;
            o_rd_addr <= '0;
            len_m1    <= last_step(i_seq_len);
          end
        end
        WAIT_X: begin
          if (xif.i_x_valid && x_ready) begin
            state   <= SETTLE;
            x_ready <= 1'b0;
            x_reg   <= xif.i_x;
            settle  <= CNT_W'(SETTLE_CYC - 1);
          end
        end
        SETTLE: begin
          if (settle == '0) state <= CAPTURE;
          else              settle <= settle - 1'b1;
        end
        CAPTURE: begin
          o_h       <= i_cell_h;
          o_h_valid <= 1'b1;
          if (o_t == len_m1) begin
            state  <= DONE;
            o_done <= 1'b1;
          end else begin
            state     <= WAIT_X;
            x_ready   <= 1'b1;
            o_t       <= o_t + 1'b1;
            o_rd_addr <= o_t + 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          o_busy    <= 1'b0;
          o_rd_addr <= '0;
        end
        UPDATE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
